// File: rtl/tile_stream_reader.sv
// Burst reader from a one-cycle-latency tile memory into a valid/ready stream.
// Optional macro TILE_READER_STRIDE_EN adds a per-command address stride input.
module tile_stream_reader #(
  parameter int W     = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
`ifdef TILE_READER_STRIDE_EN
  input  logic [AW-1:0] stride,
`endif
  output logic          busy,
  output logic          done,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [W-1:0]  mem_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic          m_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] LenOne = 1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [AW:0]   len_q, issued_q, sent_q;
  logic          inflight_q, done_q;
  logic [W-1:0]  fifo_q [3];
  logic [1:0]    wrPtr_q, rdPtr_q, count_q;

  logic          accept, push, pop, doneSet;
  logic [2:0]    occ;
  logic [AW:0]   step, addrSum;
  logic [AW-1:0] addrNext;

  // Start is refused while done is still showing so the two never coincide.
  assign accept  = (state_q == IDLE) && start && !done_q;
  assign push    = inflight_q;
  assign pop     = m_valid && m_ready;
  assign occ     = {1'b0, count_q} + {2'b00, inflight_q};
  assign doneSet = (accept && (len == '0)) || ((state_q == FLUSH) && pop && m_last);

`ifdef TILE_READER_STRIDE_EN
  logic [AW-1:0] stride_q;
  assign step = ({1'b0, stride_q} >= DepthW) ? ({1'b0, stride_q} - DepthW) : {1'b0, stride_q};
`else
  assign step = LenOne;
`endif

  // Addresses wrap modulo DEPTH even when DEPTH is not a power of two.
  assign addrSum  = {1'b0, addr_q} + step;
  assign addrNext = (addrSum >= DepthW) ? AW'(addrSum - DepthW) : addrSum[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (len != '0)) state_d = RUN;
      RUN:     if (issued_q == len_q) state_d = FLUSH;
      FLUSH:   if (pop && m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credit rule: FIFO contents plus the in-flight read never exceed three words.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    mem_re    = (state_q == RUN) && (issued_q != len_q) && (occ < 3'd3);
    mem_raddr = addr_q;
    m_valid   = (count_q != 2'd0);
    m_data    = fifo_q[rdPtr_q];
    m_last    = m_valid && (sent_q == (len_q - LenOne));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wrPtr_q    <= 2'd0;
      rdPtr_q    <= 2'd0;
      count_q    <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
`ifdef TILE_READER_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      inflight_q <= mem_re;
      done_q     <= doneSet;
      if (accept) begin
        addr_q   <= base_addr;
        len_q    <= len;
        issued_q <= '0;
        sent_q   <= '0;
`ifdef TILE_READER_STRIDE_EN
        stride_q <= stride;
`endif
      end else if (mem_re) begin
        addr_q   <= addrNext;
        issued_q <= issued_q + LenOne;
      end
      if (push) begin
        fifo_q[wrPtr_q] <= mem_rdata;
        wrPtr_q         <= (wrPtr_q == 2'd2) ? 2'd0 : wrPtr_q + 2'd1;
      end
      if (pop) begin
        rdPtr_q <= (rdPtr_q == 2'd2) ? 2'd0 : rdPtr_q + 2'd1;
        sent_q  <= sent_q + LenOne;
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_tile_stream_reader.sv
// Directed self-checking bench for tile_stream_reader against a behavioural one-cycle tile memory.
module tb_tile_stream_reader;
  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
`ifdef TILE_READER_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy, done, mem_re, m_valid, m_ready, m_last;
  logic [AW-1:0] mem_raddr;
  logic [W-1:0]  mem_rdata = '0;
  logic [W-1:0]  m_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tStart = 0;
  int doneSnap = 0;

  tile_stream_reader #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
`ifdef TILE_READER_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] memWord(input int a);
    return 32'h5A00_0000 + 32'(a) * 32'd7;
  endfunction

  // Tile memory: data appears the cycle after the read enable.
  always @(posedge clk) if (mem_re) mem_rdata <= memWord(int'(mem_raddr));

  int addrQ[$];
  int addrCycQ[$];
  logic [W-1:0] dataQ[$];
  bit lastQ[$];
  int dataCycQ[$];
  int doneCount = 0, doneCyc = 0, doneBusy = 0;
  int memReCount = 0, validCount = 0, busyCount = 0;
  int issuedCnt = 0, xferCnt = 0, maxOut = 0, creditViol = 0, stallViol = 0;
  bit prevStall = 0;
  logic [W-1:0] prevData = '0;
  bit prevLast = 0;

  // Mid-cycle monitor: logs reads, transfers, done pulses and handshake rule breaks.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 0;
    end else begin
      if (prevStall && (!m_valid || m_data !== prevData || m_last !== prevLast)) stallViol++;
      if (issuedCnt - xferCnt > maxOut) maxOut = issuedCnt - xferCnt;
      if (mem_re && (issuedCnt - xferCnt) >= 3) creditViol++;
      if (mem_re) begin
        addrQ.push_back(int'(mem_raddr));
        addrCycQ.push_back(cyc);
        memReCount++;
        issuedCnt++;
      end
      if (m_valid) validCount++;
      if (busy) busyCount++;
      if (m_valid && m_ready) begin
        dataQ.push_back(m_data);
        lastQ.push_back(m_last);
        dataCycQ.push_back(cyc);
        xferCnt++;
      end
      if (done) begin
        doneCount++;
        doneCyc = cyc;
        if (busy) doneBusy++;
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    addrQ.delete();
    addrCycQ.delete();
    dataQ.delete();
    lastQ.delete();
    dataCycQ.delete();
    memReCount = 0; validCount = 0; busyCount = 0; doneBusy = 0;
    issuedCnt = 0; xferCnt = 0; maxOut = 0; creditViol = 0; stallViol = 0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    doneSnap  = doneCount;
    tStart    = cyc;
    start     = 1'b1;
    base_addr = b;
    len       = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (doneCount == doneSnap && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, doneCount != doneSnap, 1);
  endtask

  task automatic checkStream(input string tag, input int b, input int n, input int step);
    int addrErr = 0, dataErr = 0, lastErr = 0;
    checkOutput({tag, "AddrCount"}, addrQ.size(), n);
    checkOutput({tag, "WordCount"}, dataQ.size(), n);
    for (int i = 0; i < n && i < addrQ.size(); i++)
      if (addrQ[i] != (b + i * step) % DEPTH) addrErr++;
    for (int i = 0; i < n && i < dataQ.size(); i++) begin
      if (dataQ[i] !== memWord((b + i * step) % DEPTH)) dataErr++;
      if (lastQ[i] != (i == n - 1)) lastErr++;
    end
    checkOutput({tag, "AddrErr"}, addrErr, 0);
    checkOutput({tag, "DataErr"}, dataErr, 0);
    checkOutput({tag, "LastErr"}, lastErr, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
`ifdef TILE_READER_STRIDE_EN
    stride = 1;
`endif
    @(negedge clk);
    checkOutput("rstCtl", {busy, done, mem_re, m_valid, m_last}, 0);
    checkOutput("rstAddr", mem_raddr, 0);
    checkOutput("rstData", m_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] full-rate read base=10 len=4");
    m_ready = 1'b1;
    clearLogs();
    applyStimulus(10, 4);
    checkOutput("t1Busy", busy, 1);
    waitDone("t1Done", 20);
    checkStream("t1", 10, 4, 1);
    checkOutput("t1FirstAddrCyc", (addrCycQ.size() > 0) ? addrCycQ[0] - tStart : -1, 1);
    checkOutput("t1LastAddrCyc", (addrCycQ.size() > 3) ? addrCycQ[3] - tStart : -1, 4);
    checkOutput("t1FirstWordCyc", (dataCycQ.size() > 0) ? dataCycQ[0] - tStart : -1, 3);
    checkOutput("t1LastWordCyc", (dataCycQ.size() > 3) ? dataCycQ[3] - tStart : -1, 6);
    checkOutput("t1DoneCyc", doneCyc - tStart, 7);
    checkOutput("t1DoneBusy", doneBusy, 0);

    $display("[TB] wrap-around base=DEPTH-2 len=4");
    clearLogs();
    applyStimulus(10'(DEPTH - 2), 4);
    waitDone("wrapDone", 20);
    checkStream("wrap", DEPTH - 2, 4, 1);
    checkOutput("wrapAddr2", (addrQ.size() > 2) ? addrQ[2] : -1, 0);
    checkOutput("wrapAddr3", (addrQ.size() > 3) ? addrQ[3] : -1, 1);

    $display("[TB] backpressure len=8");
    clearLogs();
    applyStimulus(100, 8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bpStallNoRead", mem_re, 0);
    checkOutput("bpStallValid", m_valid, 1);
    @(posedge clk); #1 m_ready = 1'b1;
    waitDone("bpDone", 40);
    checkStream("bp", 100, 8, 1);
    checkOutput("bpCredit", creditViol, 0);
    checkOutput("bpStable", stallViol, 0);
    checkOutput("bpMaxOutstanding", maxOut, 3);

    $display("[TB] zero length");
    clearLogs();
    applyStimulus(5, 0);
    waitDone("zDone", 5);
    checkOutput("zDoneCyc", doneCyc - tStart, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zDoneWidth", doneCount - doneSnap, 1);
    checkOutput("zNoRead", memReCount, 0);
    checkOutput("zNoValid", validCount, 0);
    checkOutput("zNoBusy", busyCount, 0);

    $display("[TB] start during RUN is ignored");
    clearLogs();
    applyStimulus(200, 6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 500; len = 2;
    checkOutput("bsBusy", busy, 1);
    @(posedge clk); #1 start = 1'b0;
    waitDone("bsDone", 30);
    repeat (5) @(posedge clk);
    #1;
    checkStream("bs", 200, 6, 1);
    checkOutput("bsOneDone", doneCount - doneSnap, 1);

    $display("[TB] full tile len=DEPTH");
    clearLogs();
    applyStimulus(0, 11'(DEPTH));
    waitDone("fullDone", DEPTH + 50);
    checkStream("full", 0, DEPTH, 1);

    $display("[TB] reset mid-command");
    clearLogs();
    applyStimulus(50, 10);
    n = 0;
    while (dataQ.size() < 3 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rmThreeWords", dataQ.size() >= 3, 1);
    doneSnap = doneCount;
    rst_n = 1'b0;
    #1;
    checkOutput("rmCtl", {busy, done, mem_re, m_valid, m_last}, 0);
    checkOutput("rmAddr", mem_raddr, 0);
    checkOutput("rmData", m_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rmNoDone", doneCount, doneSnap);
    checkOutput("rmIdle", busy, 0);
    clearLogs();
    applyStimulus(7, 2);
    waitDone("rmNextDone", 20);
    checkStream("rmNext", 7, 2, 1);

`ifdef TILE_READER_STRIDE_EN
    $display("[TB] stride=4 base=0 len=3");
    stride = 4;
    clearLogs();
    applyStimulus(0, 3);
    waitDone("strideDone", 20);
    checkStream("stride", 0, 3, 4);
    checkOutput("strideAddr2", (addrQ.size() > 2) ? addrQ[2] : -1, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
